// File: rtl/track_mixer.sv
// Multi-channel mixer: once per sample tick it fetches one word per track from the loader,
// applies gain and mute, accumulates the tracks serially and emits one saturated mono sample.
module track_mixer #(
  parameter int WORD_WIDTH   = 16,
  parameter int CHANNELS     = 4,
  parameter int GAIN_WIDTH   = 8,
  parameter int LOAD_LATENCY = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             sample_tick,
  input  logic                             enable,
  input  logic [CHANNELS-1:0]              channel_mute,
  input  logic [CHANNELS*GAIN_WIDTH-1:0]   gain,
  output logic                             mrd,
  input  logic [CHANNELS*WORD_WIDTH-1:0]   mdin,
  output logic [WORD_WIDTH-1:0]            mix_out,
  output logic                             mix_valid,
  output logic                             busy,
  output logic                             clip,
  output logic                             overrun,
  input  logic                             flags_clear
);

  localparam int PW = WORD_WIDTH + GAIN_WIDTH + 1;
  localparam int AW = PW + $clog2(CHANNELS);
  localparam int IW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int CW = (LOAD_LATENCY > 1) ? $clog2(LOAD_LATENCY) + 1 : 1;
  localparam logic [IW-1:0] LAST_IDX  = IW'(CHANNELS - 1);
  localparam logic [CW-1:0] LAST_WAIT = CW'(LOAD_LATENCY - 1);
  localparam logic [WORD_WIDTH-1:0] MAX_OUT = {1'b0, {(WORD_WIDTH-1){1'b1}}};
  localparam logic [WORD_WIDTH-1:0] MIN_OUT = {1'b1, {(WORD_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_ACC,
    S_OUT
  } state_t;

  state_t                           state_q, state_d;
  logic [CW-1:0]                    cnt_q, cnt_d;
  logic [IW-1:0]                    idx_q, idx_d;
  logic signed [AW-1:0]             acc_q, acc_d;
  logic [CHANNELS*WORD_WIDTH-1:0]   cap_data_q, cap_data_d;
  logic [CHANNELS*GAIN_WIDTH-1:0]   cap_gain_q, cap_gain_d;
  logic [CHANNELS-1:0]              cap_mute_q, cap_mute_d;
  logic                             mrd_q, mrd_d;
  logic [WORD_WIDTH-1:0]            mix_out_q, mix_out_d;
  logic                             mix_valid_q, mix_valid_d;
  logic                             clip_q, clip_d;
  logic                             overrun_q, overrun_d;

  // Per-channel scaled term from the captured sample, gain and mute.
  logic signed [AW-1:0] term [CHANNELS];

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_term
    logic signed [PW-1:0] samp_ext;
    logic signed [PW-1:0] gain_ext;
    logic signed [PW-1:0] prod;

    assign samp_ext = {{(PW-WORD_WIDTH){cap_data_q[gi*WORD_WIDTH+WORD_WIDTH-1]}},
                       cap_data_q[gi*WORD_WIDTH +: WORD_WIDTH]};
    assign gain_ext = {{(PW-GAIN_WIDTH){1'b0}}, cap_gain_q[gi*GAIN_WIDTH +: GAIN_WIDTH]};
    assign prod     = samp_ext * gain_ext;
    assign term[gi] = cap_mute_q[gi] ? '0 : AW'(prod >>> (GAIN_WIDTH - 1));
  end

  logic signed [AW-1:0] term_sel;
  logic signed [AW-1:0] acc_sum;
  logic                 ovf_pos;
  logic                 ovf_neg;

  assign term_sel = term[idx_q];
  assign acc_sum  = acc_q + term_sel;
  // The sum fits in WORD_WIDTH bits only when all bits above the output sign bit match it.
  assign ovf_pos  = !acc_sum[AW-1] && (|acc_sum[AW-2:WORD_WIDTH-1]);
  assign ovf_neg  = acc_sum[AW-1] && !(&acc_sum[AW-2:WORD_WIDTH-1]);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    cap_data_d  = cap_data_q;
    cap_gain_d  = cap_gain_q;
    cap_mute_d  = cap_mute_q;
    mrd_d       = 1'b0;
    mix_out_d   = mix_out_q;
    mix_valid_d = 1'b0;
    clip_d      = clip_q;
    overrun_d   = overrun_q;

    // Clear first so that a set event in the same cycle wins.
    if (flags_clear) begin
      clip_d    = 1'b0;
      overrun_d = 1'b0;
    end
    if (sample_tick && (state_q != S_IDLE)) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (sample_tick && enable) begin
          state_d = S_REQ;
          mrd_d   = 1'b1;
        end
      end
      S_REQ: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_WAIT) begin
          cap_data_d = mdin;
          cap_gain_d = gain;
          cap_mute_d = channel_mute;
          acc_d      = '0;
          idx_d      = '0;
          state_d    = S_ACC;
        end
      end
      S_ACC: begin
        acc_d = acc_sum;
        idx_d = idx_q + 1'b1;
        // The final channel resolves the saturated result so it lands with the OUT cycle.
        if (idx_q == LAST_IDX) begin
          idx_d       = '0;
          mix_valid_d = 1'b1;
          state_d     = S_OUT;
          if (ovf_pos) begin
            mix_out_d = MAX_OUT;
            clip_d    = 1'b1;
          end else if (ovf_neg) begin
            mix_out_d = MIN_OUT;
            clip_d    = 1'b1;
          end else begin
            mix_out_d = acc_sum[WORD_WIDTH-1:0];
          end
        end
      end
      S_OUT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      acc_q       <= '0;
      cap_data_q  <= '0;
      cap_gain_q  <= '0;
      cap_mute_q  <= '0;
      mrd_q       <= 1'b0;
      mix_out_q   <= '0;
      mix_valid_q <= 1'b0;
      clip_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      cap_data_q  <= cap_data_d;
      cap_gain_q  <= cap_gain_d;
      cap_mute_q  <= cap_mute_d;
      mrd_q       <= mrd_d;
      mix_out_q   <= mix_out_d;
      mix_valid_q <= mix_valid_d;
      clip_q      <= clip_d;
      overrun_q   <= overrun_d;
    end
  end

  assign mrd       = mrd_q;
  assign mix_out   = mix_out_q;
  assign mix_valid = mix_valid_q;
  assign clip      = clip_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_track_mixer.sv
// Directed bench for track_mixer: each scenario runs a cycle window relative to a tick at
// cycle 0, logs the outputs per cycle, then compares against hand-computed values.
module tb_track_mixer;

  logic        clk = 1'b0;
  logic        rst;
  logic        sample_tick;
  logic        enable;
  logic [3:0]  channel_mute;
  logic [31:0] gain;
  logic        mrd;
  logic [63:0] mdin;
  logic [15:0] mix_out;
  logic        mix_valid;
  logic        busy;
  logic        clip;
  logic        overrun;
  logic        flags_clear;

  int checks = 0;
  int errors = 0;

  logic               mrd_log   [32];
  logic               valid_log [32];
  logic signed [15:0] mix_log   [32];
  logic               busy_log  [32];
  logic               clip_log  [32];
  logic               ovr_log   [32];
  int                 mrd_cnt;
  int                 valid_cnt;

  always #5 clk = ~clk;

  track_mixer dut (
    .clk          (clk),
    .rst          (rst),
    .sample_tick  (sample_tick),
    .enable       (enable),
    .channel_mute (channel_mute),
    .gain         (gain),
    .mrd          (mrd),
    .mdin         (mdin),
    .mix_out      (mix_out),
    .mix_valid    (mix_valid),
    .busy         (busy),
    .clip         (clip),
    .overrun      (overrun),
    .flags_clear  (flags_clear)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input logic signed [15:0] c0, input logic signed [15:0] c1,
                          input logic signed [15:0] c2, input logic signed [15:0] c3);
    mdin = {c3, c2, c1, c0};
  endtask

  task automatic set_gain(input logic [7:0] g0, input logic [7:0] g1,
                          input logic [7:0] g2, input logic [7:0] g3);
    gain = {g3, g2, g1, g0};
  endtask

  task automatic pulse_clear();
    flags_clear = 1'b1;
    step();
    flags_clear = 1'b0;
  endtask

  // Cycle k of the window is the k-th cycle after the start; outputs are logged 1 time unit
  // after the edge that opens that cycle.
  task automatic run_window(input string name, input int ncyc, input logic [31:0] tick_mask,
                            input logic [31:0] rst_mask, input int chg_at, input int en_off_at);
    mrd_cnt   = 0;
    valid_cnt = 0;
    for (int k = 0; k < ncyc; k++) begin
      sample_tick = tick_mask[k];
      rst         = rst_mask[k];
      if (k == chg_at) begin
        mdin         = {4{16'd1000}};
        gain         = {4{8'd255}};
        channel_mute = 4'b0000;
      end
      if (k == en_off_at) enable = 1'b0;
      mrd_log[k]   = mrd;
      valid_log[k] = mix_valid;
      mix_log[k]   = mix_out;
      busy_log[k]  = busy;
      clip_log[k]  = clip;
      ovr_log[k]   = overrun;
      mrd_cnt      += int'(mrd);
      valid_cnt    += int'(mix_valid);
      step();
    end
    sample_tick = 1'b0;
    rst         = 1'b0;
    $display("txn %s: mrd pulses=%0d valid pulses=%0d mix_out=%0d clip=%0b overrun=%0b",
             name, mrd_cnt, valid_cnt, $signed(mix_out), clip, overrun);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sample_tick = 1'b1;
    repeat (3) step();
    checks++;
    if ({mrd, mix_valid, busy, clip, overrun} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got mrd/valid/busy/clip/ovr=%05b expected 00000",
               {mrd, mix_valid, busy, clip, overrun});
    end
    checks++;
    if (mix_out !== 16'd0) begin
      errors++;
      $display("FAIL reset_mix_out: got %0d expected 0", mix_out);
    end
    sample_tick = 1'b0;
    rst = 1'b0;
    step();
    $display("txn reset: outputs checked under reset");
  endtask

  task automatic test_basic();
    set_data(16'sd1000, 16'sd2000, -16'sd500, 16'sd0);
    set_gain(8'd128, 8'd128, 8'd128, 8'd128);
    run_window("basic", 12, 32'h1, 32'h0, -1, -1);
    checks++;
    if (mrd_log[1] !== 1'b1 || mrd_cnt != 1) begin
      errors++;
      $display("FAIL basic_mrd: got mrd@1=%0b pulses=%0d expected 1 and 1", mrd_log[1], mrd_cnt);
    end
    checks++;
    if (valid_log[8] !== 1'b1 || valid_cnt != 1) begin
      errors++;
      $display("FAIL basic_latency: got valid@8=%0b pulses=%0d expected 1 and 1",
               valid_log[8], valid_cnt);
    end
    checks++;
    if (mix_log[8] !== 16'sd2500) begin
      errors++;
      $display("FAIL basic_mix: got %0d expected 2500", mix_log[8]);
    end
    checks++;
    if (mix_log[7] !== 16'sd0) begin
      errors++;
      $display("FAIL basic_early_update: got %0d at cycle 7 expected 0", mix_log[7]);
    end
    checks++;
    if ({busy_log[0], busy_log[1], busy_log[8], busy_log[9]} !== 4'b0110) begin
      errors++;
      $display("FAIL basic_busy: got %04b expected 0110",
               {busy_log[0], busy_log[1], busy_log[8], busy_log[9]});
    end
    checks++;
    if (clip_log[9] !== 1'b0 || ovr_log[9] !== 1'b0) begin
      errors++;
      $display("FAIL basic_flags: got clip=%0b overrun=%0b expected 0 0", clip_log[9], ovr_log[9]);
    end
  endtask

  task automatic test_gain();
    set_data(16'sd1001, -16'sd1001, 16'sd0, 16'sd0);
    set_gain(8'd64, 8'd64, 8'd64, 8'd64);
    run_window("gain_half", 12, 32'h1, 32'h0, -1, -1);
    checks++;
    if (valid_log[8] !== 1'b1 || mix_log[8] !== -16'sd1) begin
      errors++;
      $display("FAIL gain_half_floor: got valid=%0b mix=%0d expected 1 and -1",
               valid_log[8], mix_log[8]);
    end
    set_data(16'sd100, 16'sd0, 16'sd0, 16'sd0);
    set_gain(8'd255, 8'd128, 8'd128, 8'd128);
    run_window("gain_255", 12, 32'h1, 32'h0, -1, -1);
    checks++;
    if (mix_log[8] !== 16'sd199) begin
      errors++;
      $display("FAIL gain_255: got %0d expected 199", mix_log[8]);
    end
  endtask

  task automatic test_saturation();
    set_data(16'sd30000, 16'sd30000, 16'sd30000, 16'sd30000);
    set_gain(8'd128, 8'd128, 8'd128, 8'd128);
    run_window("sat_pos", 12, 32'h1, 32'h0, -1, -1);
    checks++;
    if (mix_log[8] !== 16'sd32767 || clip_log[8] !== 1'b1) begin
      errors++;
      $display("FAIL sat_pos: got mix=%0d clip=%0b expected 32767 1", mix_log[8], clip_log[8]);
    end
    set_data(-16'sd30000, -16'sd30000, -16'sd30000, -16'sd30000);
    run_window("sat_neg", 12, 32'h1, 32'h0, -1, -1);
    checks++;
    if (mix_log[8] !== -16'sd32768) begin
      errors++;
      $display("FAIL sat_neg: got %0d expected -32768", mix_log[8]);
    end
    pulse_clear();
    checks++;
    if (clip !== 1'b0) begin
      errors++;
      $display("FAIL clip_clear: got %0b expected 0", clip);
    end
    set_data(16'sd30000, 16'sd30000, 16'sd30000, 16'sd30000);
    flags_clear = 1'b1;
    run_window("sat_clear_held", 12, 32'h1, 32'h0, -1, -1);
    flags_clear = 1'b0;
    checks++;
    if (clip_log[8] !== 1'b1 || clip_log[7] !== 1'b0) begin
      errors++;
      $display("FAIL clip_set_wins: got clip@7=%0b clip@8=%0b expected 0 1",
               clip_log[7], clip_log[8]);
    end
  endtask

  task automatic test_mute_capture();
    set_data(16'sd7, 16'sd11, 16'sd13, 16'sd17);
    set_gain(8'd128, 8'd128, 8'd128, 8'd128);
    channel_mute = 4'b0101;
    run_window("mute_capture", 12, 32'h1, 32'h0, 4, -1);
    checks++;
    if (mix_log[8] !== 16'sd28) begin
      errors++;
      $display("FAIL mute_capture: got %0d expected 28", mix_log[8]);
    end
    channel_mute = 4'b0000;
  endtask

  task automatic test_back_to_back();
    set_data(16'sd1000, 16'sd2000, -16'sd500, 16'sd0);
    set_gain(8'd128, 8'd128, 8'd128, 8'd128);
    pulse_clear();
    run_window("b2b", 20, (32'h1 | 32'h8 | 32'h200), 32'h0, -1, -1);
    checks++;
    if (mrd_cnt != 2 || mrd_log[1] !== 1'b1 || mrd_log[10] !== 1'b1) begin
      errors++;
      $display("FAIL b2b_mrd: got pulses=%0d mrd@1=%0b mrd@10=%0b expected 2 1 1",
               mrd_cnt, mrd_log[1], mrd_log[10]);
    end
    checks++;
    if (valid_cnt != 2 || valid_log[8] !== 1'b1 || valid_log[17] !== 1'b1) begin
      errors++;
      $display("FAIL b2b_valid: got pulses=%0d v@8=%0b v@17=%0b expected 2 1 1",
               valid_cnt, valid_log[8], valid_log[17]);
    end
    checks++;
    if (ovr_log[3] !== 1'b0 || ovr_log[4] !== 1'b1 || mix_log[17] !== 16'sd2500) begin
      errors++;
      $display("FAIL b2b_overrun: got ovr@3=%0b ovr@4=%0b mix@17=%0d expected 0 1 2500",
               ovr_log[3], ovr_log[4], mix_log[17]);
    end
    pulse_clear();
    run_window("tick_in_out", 14, (32'h1 | 32'h100), 32'h0, -1, -1);
    checks++;
    if (mrd_cnt != 1 || valid_cnt != 1 || ovr_log[9] !== 1'b1 || busy_log[9] !== 1'b0) begin
      errors++;
      $display("FAIL tick_in_out: got mrd=%0d valid=%0d ovr@9=%0b busy@9=%0b expected 1 1 1 0",
               mrd_cnt, valid_cnt, ovr_log[9], busy_log[9]);
    end
  endtask

  task automatic test_reset_mid();
    set_data(16'sd1000, 16'sd2000, -16'sd500, 16'sd0);
    run_window("rst_mid", 12, 32'h1, 32'h20, -1, -1);
    checks++;
    if (valid_cnt != 0) begin
      errors++;
      $display("FAIL rst_mid_valid: got %0d pulses expected 0", valid_cnt);
    end
    checks++;
    if ({busy_log[5], busy_log[6], mrd_log[6], clip_log[6], ovr_log[6]} !== 5'b10000 ||
        mix_log[6] !== 16'sd0) begin
      errors++;
      $display("FAIL rst_mid_state: got busy5/busy6/mrd/clip/ovr=%05b mix=%0d expected 10000 0",
               {busy_log[5], busy_log[6], mrd_log[6], clip_log[6], ovr_log[6]}, mix_log[6]);
    end
    run_window("rst_recover", 12, 32'h1, 32'h0, -1, -1);
    checks++;
    if (valid_log[8] !== 1'b1 || mix_log[8] !== 16'sd2500) begin
      errors++;
      $display("FAIL rst_recover: got valid=%0b mix=%0d expected 1 2500", valid_log[8], mix_log[8]);
    end
  endtask

  task automatic test_enable();
    set_data(16'sd5, 16'sd5, 16'sd5, 16'sd5);
    enable = 1'b0;
    run_window("disabled", 12, (32'h1 | 32'h10), 32'h0, -1, -1);
    checks++;
    if (mrd_cnt != 0 || valid_cnt != 0 || busy_log[1] !== 1'b0) begin
      errors++;
      $display("FAIL disabled_ticks: got mrd=%0d valid=%0d busy=%0b expected 0 0 0",
               mrd_cnt, valid_cnt, busy_log[1]);
    end
    checks++;
    if (mix_log[11] !== 16'sd2500) begin
      errors++;
      $display("FAIL disabled_hold: got %0d expected 2500", mix_log[11]);
    end
    enable = 1'b1;
    run_window("disable_mid", 14, (32'h1 | 32'h400), 32'h0, -1, 2);
    checks++;
    if (mrd_cnt != 1 || valid_cnt != 1 || mix_log[8] !== 16'sd20 || ovr_log[13] !== 1'b0) begin
      errors++;
      $display("FAIL disable_mid: got mrd=%0d valid=%0d mix=%0d ovr=%0b expected 1 1 20 0",
               mrd_cnt, valid_cnt, mix_log[8], ovr_log[13]);
    end
    enable = 1'b1;
  endtask

  initial begin
    rst          = 1'b1;
    sample_tick  = 1'b0;
    enable       = 1'b1;
    channel_mute = 4'b0000;
    gain         = {4{8'd128}};
    mdin         = '0;
    flags_clear  = 1'b0;
    step();
    test_reset();
    test_basic();
    test_gain();
    test_saturation();
    test_mute_capture();
    test_back_to_back();
    test_reset_mid();
    test_enable();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
